sync_ram_fifo_ctrl: RTL and testbench

//  - FIFO controller placed in front of the 16x16 single-port sync RAM (one access per clock, 1-cycle registered read).
//  - Converts a valid/ready push stream into RAM writes, and RAM reads into a valid/ready pop stream.
//  - Arbitrates the single RAM port between writes and reads and keeps FIFO order.
//  - Pop data is staged in a 1-entry output register.

---
 rtl/sync_ram_fifo_pkg.sv | 21 ++
 rtl/sync_ram_fifo_ctrl.sv | 138 +++++++++++++
 tb/tb_sync_ram_fifo_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_ram_fifo_pkg.sv
// ----------------------------------------------------------------------------
// sync_ram_fifo_pkg
// Shared constants and types for the FIFO controller that sits in front of the
// 16x16 single-port synchronous RAM.
//   DATA_W / ADDR_W / DEPTH : default geometry (word width, RAM address width,
//                             number of RAM words)
//   gnt_t                   : which request owns the single RAM port this cycle
// ----------------------------------------------------------------------------
package sync_ram_fifo_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {
      GNT_IDLE,
      GNT_WR,
      GNT_RD
   } gnt_t;

endpackage

// File: rtl/sync_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// sync_ram_fifo_ctrl
// FIFO controller for an external single-port sync RAM (one access per clock,
// read data registered by the RAM and valid the cycle after ram_re).  Pushes
// become RAM writes, RAM reads refill a 1-entry output register that drives
// the pop stream.  Reads win the RAM port so the output register refills as
// early as possible; FIFO order is kept by the write/read pointers.
//
// Handshake: a word moves on a port in every cycle where valid && ready are
// both high at the rising clock edge; valid never depends on ready of the
// same port, s_ready depends combinationally on m_ready.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/s_data   push stream
//   m_valid/m_ready/m_data   pop stream (m_data registered)
//   count               words held: RAM words + read in flight + output reg
//   ram_we/ram_re/ram_addr/ram_din/ram_dout   RAM port
//
// Build option
//   FIFO_CUT_THROUGH_EN : when the FIFO is completely empty and the output
//   register is free, a pushed word is loaded straight into the output
//   register (1-cycle latency) instead of making the RAM round trip.
// ----------------------------------------------------------------------------
module sync_ram_fifo_ctrl
   import sync_ram_fifo_pkg::gnt_t,
          sync_ram_fifo_pkg::GNT_IDLE,
          sync_ram_fifo_pkg::GNT_WR,
          sync_ram_fifo_pkg::GNT_RD;
#(
   parameter int DATA_W = sync_ram_fifo_pkg::DATA_W,
   parameter int ADDR_W = sync_ram_fifo_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W:0]   count,
   output logic              ram_we,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   // DEPTH is 1<<ADDR_W, expressed at the width of mem_count.
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   mem_count;
   logic              rd_inflight;
   logic              out_free;
   logic              rd_req;
   logic              rd_grant;
   logic              wr_grant;
   logic              bypass;
   logic              byp_load;
   gnt_t              gnt;

   // Output register can take a word next cycle if empty or being popped now.
   assign out_free = !m_valid || m_ready;

   // Only one read may be in flight: its data lands in the output register,
   // which must be free at that point, so the next read waits for it.
   assign rd_req   = (mem_count != '0) && !rd_inflight && out_free;
   assign rd_grant = rd_req;

`ifdef FIFO_CUT_THROUGH_EN
   // Nothing older than the incoming word exists anywhere in the FIFO.
   assign bypass = (mem_count == '0) && !rd_inflight && out_free;
`else
   assign bypass = 1'b0;
`endif

   assign s_ready  = bypass || ((mem_count != DEPTH) && !rd_grant);
   assign wr_grant = s_valid && s_ready && !bypass;
   assign byp_load = s_valid && bypass;

   always_comb begin
      gnt = GNT_IDLE;
      if (rd_grant)
         gnt = GNT_RD;
      else if (wr_grant)
         gnt = GNT_WR;
   end

   assign ram_we   = (gnt == GNT_WR);
   assign ram_re   = (gnt == GNT_RD);
   assign ram_addr = rd_grant ? rptr : wptr;
   assign ram_din  = s_data;

   assign count = mem_count + (ADDR_W+1)'(rd_inflight) + (ADDR_W+1)'(m_valid);

   // Pointers, RAM occupancy and the read-in-flight flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr        <= '0;
         rptr        <= '0;
         mem_count   <= '0;
         rd_inflight <= 1'b0;
      end else begin
         rd_inflight <= rd_grant;
         if (wr_grant)
            wptr <= wptr + ADDR_W'(1);
         if (rd_grant)
            rptr <= rptr + ADDR_W'(1);
         case ({wr_grant, rd_grant})
            2'b10:   mem_count <= mem_count + (ADDR_W+1)'(1);
            2'b01:   mem_count <= mem_count - (ADDR_W+1)'(1);
            default: mem_count <= mem_count;
         endcase
      end
   end

   // Output register.  A returning read and a bypass load never coincide
   // (bypass requires no read in flight), and either one replaces a word that
   // is being popped in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
      end else if (rd_inflight) begin
         m_valid <= 1'b1;
         m_data  <= ram_dout;
      end else if (byp_load) begin
         m_valid <= 1'b1;
         m_data  <= s_data;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sync_ram_fifo_ctrl
// Self-checking bench for sync_ram_fifo_ctrl.  A behavioural 16x16 sync RAM is
// attached to the ram_* port.  The reference is a plain FIFO queue: every
// accepted push is appended, the head must be on m_data whenever m_valid is
// high, and count must equal the number of words accepted but not yet popped.
// Build with +define+FIFO_CUT_THROUGH_EN to check the cut-through variant.
// ----------------------------------------------------------------------------
module tb_sync_ram_fifo_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
`ifdef FIFO_CUT_THROUGH_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [ADDR_W:0]   count;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   always #5 clk = ~clk;

   sync_ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .count    (count),
      .ram_we   (ram_we),
      .ram_re   (ram_re),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // Behavioural single-port sync RAM, contents never cleared.
   logic [DATA_W-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      ram_dout = '0;
   end
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_re) ram_dout <= mem[ram_addr];
   end

   // ---------------- scoreboard state ----------------
   logic [DATA_W-1:0] exp_q[$];
   int                checks = 0;
   int                errors = 0;
   int                cyc = 0;
   int                max_count = 0;
   int                n_pops = 0;
   logic [DATA_W-1:0] last_pop = '0;
   logic              acc;
   logic              pop;

   // ---------------- driver tasks ----------------
   // One clock cycle: inputs are already driven (at the falling edge); sample
   // outputs, check against the queue, record transfers, advance to the next
   // falling edge.
   task automatic step();
      #1;
      checks++;
      if (int'(count) !== exp_q.size()) begin
         errors++;
         $display("FAIL sb_count: cyc=%0d count=%0d expected=%0d", cyc, count, exp_q.size());
      end
      checks++;
      if (int'(count) > DEPTH + 1) begin
         errors++;
         $display("FAIL sb_count_max: cyc=%0d count=%0d limit=%0d", cyc, count, DEPTH + 1);
      end
      checks++;
      if ((ram_we && ram_re) !== 1'b0) begin
         errors++;
         $display("FAIL sb_port_excl: cyc=%0d ram_we=%b ram_re=%b expected not both", cyc, ram_we, ram_re);
      end
      if (ram_re === 1'b1) begin
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL sb_read_prio: cyc=%0d s_ready=%b expected 0 during ram_re", cyc, s_ready);
         end
      end
      if (exp_q.size() == 0) begin
         checks++;
         if (m_valid !== 1'b0 || ram_re !== 1'b0) begin
            errors++;
            $display("FAIL sb_empty: cyc=%0d m_valid=%b ram_re=%b expected 0/0", cyc, m_valid, ram_re);
         end
      end else if (m_valid === 1'b1) begin
         checks++;
         if (m_data !== exp_q[0]) begin
            errors++;
            $display("FAIL sb_head: cyc=%0d m_data=%h expected=%h", cyc, m_data, exp_q[0]);
         end
      end
      if (int'(count) > max_count) max_count = int'(count);
      acc = s_valid && s_ready;
      pop = m_valid && m_ready;
      if (pop && exp_q.size() > 0) begin
         last_pop = exp_q.pop_front();
         n_pops++;
      end
      if (acc) exp_q.push_back(s_data);
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   // Pop everything with pushes idle, bounded.
   task automatic drain(input int bound);
      int n;
      s_valid = 1'b0;
      m_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < bound) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || count !== '0) begin
         errors++;
         $display("FAIL drain_timeout: left=%0d count=%0d expected 0", exp_q.size(), count);
      end
      m_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      s_valid = 1'b0;
      s_data = '0;
      m_ready = 1'b0;
      #2;
      checks++;
      if (count !== '0 || m_valid !== 1'b0 || m_data !== '0) begin
         errors++;
         $display("FAIL reset_state: count=%0d m_valid=%b m_data=%h expected 0/0/0", count, m_valid, m_data);
      end
      checks++;
      if (ram_we !== 1'b0 || ram_re !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ports: we=%b re=%b s_ready=%b expected 0/0/1", ram_we, ram_re, s_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_push_after_reset();
      logic [DATA_W-1:0] words [3];
      int idx;
      int push_cyc;
      int mv_cyc;
      words[0] = 16'h1111;
      words[1] = 16'h2222;
      words[2] = 16'h3333;
      idx = 0;
      push_cyc = -1;
      mv_cyc = -1;
      m_ready = 1'b0;
      for (int n = 0; n < 20 && idx < 3; n++) begin
         s_valid = 1'b1;
         s_data = words[idx];
         if (acc === 1'b1 && push_cyc < 0) push_cyc = cyc - 1;
         step();
         if (acc) begin
            if (push_cyc < 0) push_cyc = cyc - 1;
            idx++;
         end
         if (m_valid && mv_cyc < 0) mv_cyc = cyc;
      end
      s_valid = 1'b0;
      for (int n = 0; n < 5 && mv_cyc < 0; n++) begin
         step();
         if (m_valid && mv_cyc < 0) mv_cyc = cyc;
      end
      checks++;
      if (mv_cyc - push_cyc !== LAT) begin
         errors++;
         $display("FAIL push_latency: got=%0d expected=%0d", mv_cyc - push_cyc, LAT);
      end
      step();
      checks++;
      if (m_data !== 16'h1111 || count !== 5'd3 || m_valid !== 1'b1) begin
         errors++;
         $display("FAIL push_state: m_data=%h count=%0d m_valid=%b expected 1111/3/1", m_data, count, m_valid);
      end
   endtask

   // Continues from 1111 in the output register and two words in RAM.
   task automatic test_arbitration();
      s_valid = 1'b1;
      s_data = 16'h4444;
      m_ready = 1'b1;
      #1;
      checks++;
      if (ram_re !== 1'b1 || s_ready !== 1'b0 || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL arb_read_wins: re=%b s_ready=%b we=%b expected 1/0/0", ram_re, s_ready, ram_we);
      end
      step();
      m_ready = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1 || ram_we !== 1'b1) begin
         errors++;
         $display("FAIL arb_write_next: s_ready=%b we=%b expected 1/1", s_ready, ram_we);
      end
      step();
      drain(50);
   endtask

   task automatic test_fill_full();
      m_ready = 1'b0;
      max_count = 0;
      for (int n = 0; n < 60; n++) begin
         s_valid = 1'b1;
         s_data = DATA_W'($urandom);
         step();
      end
      s_valid = 1'b1;
      #1;
      checks++;
      if (count !== 5'd17 || s_ready !== 1'b0 || max_count != 17) begin
         errors++;
         $display("FAIL full: count=%0d s_ready=%b max=%0d expected 17/0/17", count, s_ready, max_count);
      end
   endtask

   task automatic test_drain_after_full();
      n_pops = 0;
      drain(100);
      checks++;
      if (n_pops != 17) begin
         errors++;
         $display("FAIL drain_pops: got=%0d expected=17", n_pops);
      end
   endtask

   task automatic test_stream_wrap();
      int idx;
      idx = 0;
      n_pops = 0;
      max_count = 0;
      m_ready = 1'b1;
      for (int n = 0; n < 400 && n_pops < 40; n++) begin
         s_valid = (idx < 40) && ($urandom_range(0, 3) != 0);
         s_data = DATA_W'(idx);
         step();
         if (acc) idx++;
      end
      s_valid = 1'b0;
      checks++;
      if (n_pops != 40 || last_pop !== 16'h0027 || max_count > 17) begin
         errors++;
         $display("FAIL stream: pops=%0d last=%h max=%0d expected 40/0027/<=17", n_pops, last_pop, max_count);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 500; n++) begin
         s_valid = ($urandom_range(0, 2) != 0);
         s_data = DATA_W'($urandom);
         m_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
         step();
      end
      drain(100);
   endtask

   task automatic test_reset_mid_op();
      int pushed;
      pushed = 0;
      m_ready = 1'b0;
      for (int n = 0; n < 40 && pushed < 6; n++) begin
         s_valid = 1'b1;
         s_data = DATA_W'($urandom);
         step();
         if (acc) pushed++;
      end
      s_valid = 1'b0;
      for (int n = 0; n < 4; n++) step();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      checks++;
      if (count !== 5'd5) begin
         errors++;
         $display("FAIL midrst_setup: count=%0d expected=5", count);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || count !== '0 || ram_re !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: m_valid=%b count=%0d re=%b expected 0/0/0", m_valid, count, ram_re);
      end
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b1;
      s_data = 16'hBEEF;
      for (int n = 0; n < 5; n++) begin
         step();
         if (acc) break;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      n_pops = 0;
      for (int n = 0; n < 20 && n_pops == 0; n++) step();
      checks++;
      if (n_pops != 1 || last_pop !== 16'hBEEF) begin
         errors++;
         $display("FAIL midrst_first: pops=%0d data=%h expected 1/BEEF", n_pops, last_pop);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_cut_through();
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data = 16'hABCD;
      #1;
      checks++;
`ifdef FIFO_CUT_THROUGH_EN
      if (ram_we !== 1'b0 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL ct_no_write: we=%b s_ready=%b expected 0/1", ram_we, s_ready);
      end
`else
      if (ram_we !== 1'b1 || s_ready !== 1'b1) begin
         errors++;
         $display("FAIL ct_write: we=%b s_ready=%b expected 1/1", ram_we, s_ready);
      end
`endif
      step();
      s_valid = 1'b0;
      #1;
      checks++;
`ifdef FIFO_CUT_THROUGH_EN
      if (m_valid !== 1'b1 || m_data !== 16'hABCD || ram_we !== 1'b0) begin
         errors++;
         $display("FAIL ct_next: m_valid=%b m_data=%h we=%b expected 1/ABCD/0", m_valid, m_data, ram_we);
      end
`else
      if (m_valid !== 1'b0 || ram_re !== 1'b1) begin
         errors++;
         $display("FAIL ct_next: m_valid=%b re=%b expected 0/1", m_valid, ram_re);
      end
`endif
      drain(20);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      acc = 1'b0;
      pop = 1'b0;
      test_reset();
      test_push_after_reset();
      test_arbitration();
      test_fill_full();
      test_drain_after_full();
      test_stream_wrap();
      test_random();
      test_reset_mid_op();
      test_cut_through();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
